// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Sequential restoring unsigned divider (shift-subtract). Each
//             quotient bit takes two cycles: one SHIFT and one SUB. Divide by
//             zero is detected right after LOAD. In that case the quotient is
//             all ones, the remainder is the dividend, and div_by_zero is set.
//  Ports    :
//    clk         in   1      rising-edge clock
//    clr_n       in   1      asynchronous active-low reset
//    go          in   1      start request, sampled only in IDLE
//    dividend    in   WIDTH  unsigned dividend, sampled at end of LOAD
//    divisor     in   WIDTH  unsigned divisor, sampled at end of LOAD
//    quotient    out  WIDTH  registered quotient
//    remainder   out  WIDTH  registered remainder
//    busy        out  1      high in every state except IDLE
//    done        out  1      one-cycle pulse in DONE
//    div_by_zero out  1      set when the sampled divisor was zero
//  Revision : 1.0  initial release
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             go,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_SHIFT = 3'd3,
    S_SUB   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH:0]     r_q, r_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     w_d_ext;
  logic [WIDTH:0]     w_diff;
  logic               w_fits;

  // After a shift R < 2*D, so one extra bit keeps the compare and the
  // subtraction exact.
  assign w_d_ext = {1'b0, d_q};
  assign w_diff  = r_q - w_d_ext;
  assign w_fits  = (r_q >= w_d_ext);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (go) state_d = S_LOAD;
      end
      S_LOAD: begin
        q_d     = dividend;
        d_d     = divisor;
        r_d     = '0;
        cnt_d   = CNT_W'(WIDTH);
        dbz_d   = 1'b0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (d_q == '0) begin
          // Q still holds the dividend here, so it becomes the remainder.
          dbz_d   = 1'b1;
          q_d     = '1;
          r_d     = {1'b0, q_q};
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // {R,Q} shifts left as one register. R's MSB is always zero here
        // because R < D after the previous SUB.
        r_d     = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        q_d     = {q_q[WIDTH-2:0], 1'b0};
        state_d = S_SUB;
      end
      S_SUB: begin
        if (w_fits) begin
          r_d    = w_diff;
          q_d[0] = 1'b1;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        else                    state_d = S_SHIFT;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign quotient    = q_q;
  assign remainder   = r_q[WIDTH-1:0];
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Self-checking bench for seq_divider (WIDTH=8). The driver
//             pushes the expected result of each operation into a queue. A
//             monitor pops and compares whenever done is high.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_divider;

  logic       clk;
  logic       clr_n;
  logic       go;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pushed = 0;
  int   n_done   = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .go         (go),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] q, input logic [7:0] r, input logic dbz);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz;
    sb.push_back(e);
    n_pushed++;
  endtask

  // Monitor: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (clr_n && done) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", {24'd0, quotient}, {24'd0, e.q});
        chk("remainder", {24'd0, remainder}, {24'd0, e.r});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
      end
    end
  end

  // Wait (bounded) for done, counting edges since the go-sampling edge.
  task automatic wait_done(input int exp_lat, input int mode);
    int lat;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); lat++; #1;
      if (lat == 1) chk("dbz_clear_at_load", {31'd0, div_by_zero}, 32'd0);
      if (lat >= 1 && !done) chk("busy_during_op", {31'd0, busy}, 32'd1);
      if (mode == 1 && lat == 5) begin
        go = 1'b1; dividend = 8'd1; divisor = 8'd1;
      end
      if (mode == 1 && lat == 6) go = 1'b0;
    end
    chk("latency", lat, exp_lat);
  endtask

  // mode 0: plain op; mode 1: disturb go/operands at edge 6.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic ed, input int exp_lat, input int mode);
    @(negedge clk);
    dividend = a; divisor = b; go = 1'b1;
    push_exp(eq, er, ed);
    @(posedge clk); #1;
    go = 1'b0;
    chk("busy_edge0", {31'd0, busy}, 32'd1);
    wait_done(exp_lat, mode);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    clr_n = 1'b0; go = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_quotient", {24'd0, quotient}, 32'd0);
    chk("rst_remainder", {24'd0, remainder}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk); clr_n = 1'b1;

    run_op(8'd100, 8'd7,  8'd14,  8'd2,  1'b0, 18, 0);
    run_op(8'd255, 8'd1,  8'd255, 8'd0,  1'b0, 18, 0);
    run_op(8'd5,   8'd9,  8'd0,   8'd5,  1'b0, 18, 0);
    run_op(8'd42,  8'd0,  8'd255, 8'd42, 1'b1, 2,  0);
    run_op(8'd0,   8'd3,  8'd0,   8'd0,  1'b0, 18, 0);
    run_op(8'd255, 8'd255,8'd1,   8'd0,  1'b0, 18, 0);
    run_op(8'd200, 8'd13, 8'd15,  8'd5,  1'b0, 18, 1);
    repeat (3) @(posedge clk);
    #1 chk("stray_go_ignored", {31'd0, busy}, 32'd0);

    // go held high through DONE: a second op starts from the IDLE cycle.
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; go = 1'b1;
    push_exp(8'd14, 8'd2, 1'b0);
    push_exp(8'd12, 8'd0, 1'b0);
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); lat++; #1;
      if (lat == 2) begin dividend = 8'd60; divisor = 8'd5; end
    end
    chk("hold_go_latency1", lat, 18);
    @(posedge clk); #1;
    chk("hold_go_idle_cycle", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("hold_go_restart", {31'd0, busy}, 32'd1);
    go = 1'b0;
    wait_done(18, 0);
    @(posedge clk); #1;

    // Reset mid-operation at edge 9.
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (9) @(posedge clk);
    #1 clr_n = 1'b0;
    #1;
    chk("abort_quotient", {24'd0, quotient}, 32'd0);
    chk("abort_remainder", {24'd0, remainder}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk); clr_n = 1'b1;
    run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 18, 0);

    // Sweep of operand pairs with nonzero divisor.
    for (int i = 0; i < 500; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      run_op(a, b, a / b, a % b, 1'b0, 18, 0);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 32'd0);
    chk("done_count", n_done, n_pushed);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential restoring unsigned divider (shift-subtract). It is the inverse-operation counterpart to the team's shift-add sequential multiplier, with the same go/start handshake style. Controller FSM and datapath sit in one block and produce one quotient bit per two cycles. It is used alongside the multiplier wherever the arithmetic unit needs quotient/remainder.

Parameters:
WIDTH, 8, operand/quotient/remainder width in bits (>=2)

Ports:
clk  input  1  rising-edge clock
clr_n  input  1  asynchronous active-low reset
go  input  1  start request, sampled only in IDLE
dividend  input  WIDTH  unsigned dividend, sampled at end of LOAD
divisor  input  WIDTH  unsigned divisor, sampled at end of LOAD
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse in DONE state
div_by_zero  output  1  registered flag, set when divisor==0

Behaviour:
- Reset (clr_n=0, async): state=IDLE; quotient, remainder, internal R/D/count = 0; busy=0, done=0, div_by_zero=0.
- Reset mid-operation aborts immediately, with the same values as above. No partial result is retained.
- Internal regs: Q (WIDTH, becomes quotient), R (WIDTH+1, partial remainder), D (WIDTH), cnt (clog2(WIDTH)+1).
- quotient = Q and remainder = R[WIDTH-1:0] are driven continuously from the regs. They are valid only from the DONE cycle until the next LOAD edge, and hold their values in IDLE.
- States and transitions:
  - IDLE: go=1 -> LOAD, else stay.
  - LOAD: on exit edge Q<=dividend, D<=divisor, R<=0, cnt<=WIDTH, div_by_zero<=0. -> CHECK.
  - CHECK: if D==0, then div_by_zero<=1, Q<=all ones, R<=dividend held in Q (zero-extended), -> DONE. Else -> SHIFT.
  - SHIFT: {R,Q} <= {R,Q} shifted left 1, LSB of Q <= 0. -> SUB.
  - SUB: if R >= {1'b0,D}, then R<=R-D and Q[0]<=1. cnt<=cnt-1. If cnt==1 -> DONE, else -> SHIFT.
  - DONE: done=1 for exactly one cycle. -> IDLE unconditionally.
- Outputs are Moore outputs: busy=(state!=IDLE), done=(state==DONE).
- go is ignored in every state other than IDLE, including go held high. A go held high through DONE starts a new operation on the IDLE cycle after DONE.
- dividend and divisor must be stable during the LOAD cycle. Changes at any other time have no effect on the operation in progress.
- Latency: with the go-sampling edge as edge 0, DONE is entered at edge 2*WIDTH+2 (edge 18 for WIDTH=8). For divide-by-zero, DONE is entered at edge 2.
- R never exceeds 2*D-1 after a shift, so WIDTH+1 bits suffice and no overflow is possible.
- Result identity for D!=0: dividend == quotient*divisor + remainder, with remainder < divisor.

Test Plan:
- WIDTH=8, dividend=100, divisor=7, go pulse: busy high from edge 0; done pulses after edge 18; quotient=14, remainder=2, div_by_zero=0.
- dividend=255, divisor=1 -> quotient=255, remainder=0. Then dividend=5, divisor=9 -> quotient=0, remainder=5. Both done after edge 18.
- dividend=42, divisor=0 -> done after edge 2, div_by_zero=1, quotient=255, remainder=42. The next valid division clears div_by_zero on its LOAD exit edge.
- Second go pulse and operand changes applied mid-division (edge 6) during 200/13: both ignored; result quotient=15, remainder=5. Holding go high through DONE: a new operation starts the cycle after DONE.
- clr_n low at edge 9 of 100/7: outputs and state return to zero/IDLE at once. A fresh 100/7 then completes normally with 14 r 2.
- Randomised sweep of 500 operand pairs with nonzero divisor: check quotient*divisor+remainder==dividend and remainder<divisor; done count equals go-accept count.
